// File: rtl/data_array_refill_ctrl_pkg.sv
// Shared types and default geometry for the data-array refill controller.
// The controller assembles refill beats into a row and arbitrates the array against core accesses.
package data_array_refill_ctrl_pkg;

   localparam int DEF_ADDR_W = 9;
   localparam int DEF_BEAT_W = 64;
   localparam int DEF_BEATS  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FILL  = 2'd1,
      WRITE = 2'd2
   } state_t;

   // Beat counter width; a single-beat row still needs a 1-bit counter.
   function automatic int cnt_width(input int beats);
      return (beats > 1) ? $clog2(beats) : 1;
   endfunction

endpackage

// File: rtl/data_array_refill_ctrl_row_buffer.sv
// Beat counter plus row assembly register for refill data.
// Each accepted beat lands at the slot selected by the counter, which wraps after the last beat.
module refill_row_buffer
   import data_array_refill_ctrl_pkg::*;
#(
   parameter int BEAT_W = DEF_BEAT_W,
   parameter int BEATS  = DEF_BEATS,
   parameter int ROW_W  = DEF_BEAT_W * DEF_BEATS
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              beat_load,
   input  logic [BEAT_W-1:0] beat_data,
   output logic              last_beat,
   output logic [ROW_W-1:0]  row
);

   localparam int CNT_W = cnt_width(BEATS);

   logic [CNT_W-1:0] beat_cnt;

   assign last_beat = (beat_cnt == CNT_W'(BEATS - 1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         beat_cnt <= '0;
         row      <= '0;
      end else if (beat_load) begin
         for (int k = 0; k < BEATS; k++) begin
            if (beat_cnt == CNT_W'(k)) begin
               row[k*BEAT_W +: BEAT_W] <= beat_data;
            end
         end
         beat_cnt <= last_beat ? '0 : beat_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/data_array_refill_ctrl.sv
// Refill controller for a single-port data array: collects refill beats into a row,
// writes the row in one cycle, and passes core reads/writes straight through otherwise.
module data_array_refill_ctrl
   import data_array_refill_ctrl_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int BEAT_W = DEF_BEAT_W,
   parameter int BEATS  = DEF_BEATS,
   parameter int ROW_W  = DEF_BEAT_W * DEF_BEATS
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 refill_valid,
   output logic                 refill_ready,
   input  logic [ADDR_W-1:0]    refill_idx,
   input  logic [BEAT_W-1:0]    refill_data,
   output logic                 refill_done,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_write,
   input  logic [ADDR_W-1:0]    req_addr,
   input  logic [ROW_W/8-1:0]   req_wmask,
   input  logic [ROW_W-1:0]     req_wdata,
   output logic                 resp_valid,
   output logic [ROW_W-1:0]     resp_data,
   output logic                 RW0_en,
   output logic                 RW0_wmode,
   output logic [ADDR_W-1:0]    RW0_addr,
   output logic [ROW_W/8-1:0]   RW0_wmask,
   output logic [ROW_W-1:0]     RW0_wdata,
   input  logic [ROW_W-1:0]     RW0_rdata
);

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never depends on ready, ready may depend on the request address.

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   idx_q;
   logic [ROW_W-1:0]    row;
   logic                last_beat;
   logic                beat_acc;
   logic                req_acc;
   logic                resp_valid_q;

   assign refill_ready = (state_q != WRITE);
   assign beat_acc     = refill_valid && refill_ready;
   assign refill_done  = (state_q == WRITE);

   // A core access to the row being filled would see stale data, so it waits for the write.
   assign req_ready = (state_q != WRITE) &&
                      !((state_q == FILL) && (req_addr == idx_q));
   assign req_acc   = req_valid && req_ready;

   refill_row_buffer #(
      .BEAT_W (BEAT_W),
      .BEATS  (BEATS),
      .ROW_W  (ROW_W)
   ) u_row_buffer (
      .clock     (clock),
      .reset     (reset),
      .beat_load (beat_acc),
      .beat_data (refill_data),
      .last_beat (last_beat),
      .row       (row)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         resp_valid_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         resp_valid_q <= req_acc && !req_write;
         if ((state_q == IDLE) && beat_acc) begin
            idx_q <= refill_idx;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, FILL: begin
            if (beat_acc) begin
               state_d = last_beat ? WRITE : FILL;
            end
         end
         WRITE:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Array port: the refill write owns WRITE; otherwise an accepted core request drives it.
   always_comb begin
      RW0_en    = 1'b0;
      RW0_wmode = 1'b0;
      RW0_addr  = '0;
      RW0_wmask = '0;
      RW0_wdata = '0;
      if (state_q == WRITE) begin
         RW0_en    = 1'b1;
         RW0_wmode = 1'b1;
         RW0_addr  = idx_q;
         RW0_wmask = '1;
         RW0_wdata = row;
      end else if (req_acc) begin
         RW0_en    = 1'b1;
         RW0_wmode = req_write;
         RW0_addr  = req_addr;
         if (req_write) begin
            RW0_wmask = req_wmask;
            RW0_wdata = req_wdata;
         end
      end
   end

   assign resp_valid = resp_valid_q;
   assign resp_data  = resp_valid_q ? RW0_rdata : '0;

endmodule

// File: tb/tb_data_array_refill_ctrl.sv
// Bench for data_array_refill_ctrl: a behavioural array, a shadow memory with expected-response
// queue, directed refill/hazard/reset scenarios, then randomized traffic.
module tb_data_array_refill_ctrl;

   localparam int AW = 9;
   localparam int BW = 64;
   localparam int NB = 4;
   localparam int RW = 256;
   localparam int MW = RW / 8;

   logic           clock = 1'b0;
   logic           reset = 1'b1;
   logic           refill_valid = 1'b0;
   logic           refill_ready;
   logic [AW-1:0]  refill_idx = '0;
   logic [BW-1:0]  refill_data = '0;
   logic           refill_done;
   logic           req_valid = 1'b0;
   logic           req_ready;
   logic           req_write = 1'b0;
   logic [AW-1:0]  req_addr = '0;
   logic [MW-1:0]  req_wmask = '0;
   logic [RW-1:0]  req_wdata = '0;
   logic           resp_valid;
   logic [RW-1:0]  resp_data;
   logic           RW0_en;
   logic           RW0_wmode;
   logic [AW-1:0]  RW0_addr;
   logic [MW-1:0]  RW0_wmask;
   logic [RW-1:0]  RW0_wdata;
   logic [RW-1:0]  RW0_rdata = '0;

   int vectors = 0;
   int miscompares = 0;

   data_array_refill_ctrl #(
      .ADDR_W (AW),
      .BEAT_W (BW),
      .BEATS  (NB),
      .ROW_W  (RW)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .refill_valid (refill_valid),
      .refill_ready (refill_ready),
      .refill_idx   (refill_idx),
      .refill_data  (refill_data),
      .refill_done  (refill_done),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_write    (req_write),
      .req_addr     (req_addr),
      .req_wmask    (req_wmask),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_data    (resp_data),
      .RW0_en       (RW0_en),
      .RW0_wmode    (RW0_wmode),
      .RW0_addr     (RW0_addr),
      .RW0_wmask    (RW0_wmask),
      .RW0_wdata    (RW0_wdata),
      .RW0_rdata    (RW0_rdata)
   );

   // ---------------- clock ----------------
   always #5 clock = ~clock;

   // ---------------- behavioural single-port array ----------------
   logic [RW-1:0] arr [0:(1<<AW)-1];

   always @(posedge clock) begin
      if (RW0_en) begin
         if (RW0_wmode) begin
            for (int b = 0; b < MW; b++) begin
               if (RW0_wmask[b]) arr[RW0_addr][b*8 +: 8] <= RW0_wdata[b*8 +: 8];
            end
         end else begin
            RW0_rdata <= arr[RW0_addr];
         end
      end
   end

   // ---------------- reference model state ----------------
   logic [RW-1:0] ref_mem [0:(1<<AW)-1];
   logic [RW-1:0] exp_q [$];
   int            beats = 0;
   logic [AW-1:0] fill_idx = '0;
   logic [RW-1:0] fill_row = '0;
   bit            write_now = 1'b0;
   logic [AW-1:0] w_idx = '0;
   logic [RW-1:0] w_row = '0;

   task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [RW-1:0] rand_row();
      logic [RW-1:0] r;
      for (int i = 0; i < RW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clock) begin
      bit            rdy_refill;
      bit            rdy_req;
      logic [RW-1:0] merged;
      if (reset) begin
         chk("reset_en", RW0_en, 0);
         chk("reset_resp_valid", resp_valid, 0);
         chk("reset_done", refill_done, 0);
         beats = 0;
         write_now = 1'b0;
         exp_q.delete();
      end else begin
         rdy_refill = !write_now;
         rdy_req    = !write_now && !((beats > 0) && (req_addr == fill_idx));
         chk("refill_ready", refill_ready, rdy_refill);
         if (req_valid) chk("req_ready", req_ready, rdy_req);

         chk("resp_valid", resp_valid, exp_q.size() > 0);
         if (resp_valid && exp_q.size() > 0) chk("resp_data", resp_data, exp_q.pop_front());

         if (write_now) begin
            chk("fill_en", RW0_en, 1);
            chk("fill_wmode", RW0_wmode, 1);
            chk("fill_addr", RW0_addr, w_idx);
            chk("fill_wmask", RW0_wmask, {MW{1'b1}});
            chk("fill_wdata", RW0_wdata, w_row);
            chk("fill_done", refill_done, 1);
            ref_mem[w_idx] = w_row;
            write_now = 1'b0;
         end else if (req_valid && rdy_req) begin
            chk("req_en", RW0_en, 1);
            chk("req_wmode", RW0_wmode, req_write);
            chk("req_addr", RW0_addr, req_addr);
            chk("req_wmask", RW0_wmask, req_write ? req_wmask : '0);
            chk("req_done", refill_done, 0);
            if (req_write) begin
               chk("req_wdata", RW0_wdata, req_wdata);
               merged = ref_mem[req_addr];
               for (int b = 0; b < MW; b++) begin
                  if (req_wmask[b]) merged[b*8 +: 8] = req_wdata[b*8 +: 8];
               end
               ref_mem[req_addr] = merged;
            end else begin
               exp_q.push_back(ref_mem[req_addr]);
            end
         end else begin
            chk("idle_en", RW0_en, 0);
            chk("idle_wmode", RW0_wmode, 0);
            chk("idle_wmask", RW0_wmask, 0);
            chk("idle_wdata", RW0_wdata, 0);
            chk("idle_done", refill_done, 0);
         end

         if (refill_valid && rdy_refill) begin
            if (beats == 0) fill_idx = refill_idx;
            fill_row[beats*BW +: BW] = refill_data;
            beats++;
            if (beats == NB) begin
               w_idx = fill_idx;
               w_row = fill_row;
               write_now = 1'b1;
               beats = 0;
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic cyc(input bit rv, input logic [AW-1:0] ri, input logic [BW-1:0] rd,
                      input bit qv, input bit qw, input logic [AW-1:0] qa,
                      input logic [MW-1:0] qm, input logic [RW-1:0] qd);
      refill_valid = rv;
      refill_idx   = ri;
      refill_data  = rd;
      req_valid    = qv;
      req_write    = qw;
      req_addr     = qa;
      req_wmask    = qm;
      req_wdata    = qd;
      @(posedge clock);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(0, '0, '0, 0, 0, '0, '0, '0);
   endtask

   task automatic beat(input logic [AW-1:0] ri, input logic [BW-1:0] rd);
      cyc(1, ri, rd, 0, 0, '0, '0, '0);
   endtask

   task automatic rd_req(input logic [AW-1:0] qa);
      cyc(0, '0, '0, 1, 0, qa, '0, '0);
   endtask

   task automatic hold_reset(input int n);
      refill_valid = 1'b0;
      req_valid    = 1'b0;
      reset        = 1'b1;
      #1;
      chk("async_reset_en", RW0_en, 0);
      chk("async_reset_done", refill_done, 0);
      repeat (n) @(posedge clock);
      #1;
      reset = 1'b0;
   endtask

   function automatic logic [AW-1:0] pick_addr();
      case ($urandom_range(0, 3))
         0:       return 9'h1A3;
         1:       return 9'h005;
         2:       return 9'h010;
         default: return AW'($urandom_range(0, (1 << AW) - 1));
      endcase
   endfunction

   // ---------------- stimulus ----------------
   initial begin
      logic [RW-1:0] v;
      for (int i = 0; i < (1 << AW); i++) begin
         v = rand_row();
         arr[i] = v;
         ref_mem[i] = v;
      end
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b0;
      idle(2);

      // Refill of 0x1A3 with a side read to 0x005 and a blocked read to the filling row.
      beat(9'h1A3, {8{8'h11}});
      cyc(1, 9'h000, {8{8'h22}}, 1, 0, 9'h005, '0, '0);
      cyc(1, 9'h000, {8{8'h33}}, 1, 0, 9'h1A3, '0, '0);
      cyc(1, 9'h000, {8{8'h44}}, 1, 0, 9'h1A3, '0, '0);
      chk("write_state_done", refill_done, 1);
      chk("write_state_req_ready", req_ready, 0);
      rd_req(9'h1A3);
      rd_req(9'h1A3);
      idle(2);
      chk("row_1a3", ref_mem[9'h1A3], {{8{8'h44}}, {8{8'h33}}, {8{8'h22}}, {8{8'h11}}});

      // Partial byte write followed by a read-back.
      cyc(0, '0, '0, 1, 1, 9'h010, 32'h0000_000F, rand_row());
      rd_req(9'h010);
      idle(2);

      // Reset after two beats, then a fresh complete refill of the same row.
      beat(9'h0AA, 64'hDEAD_0000_0000_0001);
      beat(9'h0AA, 64'hDEAD_0000_0000_0002);
      hold_reset(2);
      idle(1);
      for (int k = 0; k < NB; k++) beat(9'h0AA, {$urandom, $urandom});
      idle(1);
      rd_req(9'h0AA);
      idle(2);

      // Reset landing in the write cycle must suppress the array write.
      for (int k = 0; k < NB; k++) beat(9'h055, {$urandom, $urandom});
      chk("pre_reset_done", refill_done, 1);
      hold_reset(2);
      idle(1);
      rd_req(9'h055);
      idle(2);

      // Randomized mixed traffic.
      for (int n = 0; n < 3000; n++) begin
         cyc($urandom_range(0, 1), pick_addr(), {$urandom, $urandom},
             $urandom_range(0, 2) != 0, $urandom_range(0, 2) == 0, pick_addr(),
             $urandom, rand_row());
      end
      idle(4);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_array_refill_ctrl.md
DATA_ARRAY_REFILL_CTRL -- requirements
Module: data_array_refill_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDR_W, 9, row index width.
- BEAT_W, 64, refill beat width.
- BEATS, 4, beats per row.
- ROW_W, 256, row width; SHALL equal BEAT_W*BEATS.
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clock, in, 1, single clock; all state on its rising edge.
- reset, in, 1, asynchronous, active-high.
- refill_valid, in, 1, refill beat valid.
- refill_ready, out, 1, refill beat accepted when valid&&ready.
- refill_idx, in, ADDR_W, target row; sampled on first beat only.
- refill_data, in, BEAT_W, beat payload.
- refill_done, out, 1, one-cycle pulse on row write.
- req_valid, in, 1, core access valid.
- req_ready, out, 1, core access accepted when valid&&ready.
- req_write, in, 1, 1 = write, 0 = read.
- req_addr, in, ADDR_W, core row address.
- req_wmask, in, ROW_W/8, byte write enables.
- req_wdata, in, ROW_W, write data.
- resp_valid, out, 1, read data valid.
- resp_data, out, ROW_W, read data.
- RW0_en, out, 1, array enable.
- RW0_wmode, out, 1, array write mode.
- RW0_addr, out, ADDR_W, array address.
- RW0_wmask, out, ROW_W/8, array byte mask.
- RW0_wdata, out, ROW_W, array write data.
- RW0_rdata, in, ROW_W, array read data, valid one cycle after a read enable.

Function
REQ-003 FSM SHALL have states IDLE, FILL, WRITE.
REQ-004 Accepting a beat in IDLE SHALL do all of the following: latch refill_idx, store the beat at bits [BEAT_W-1:0], set beat_cnt=1, and go to FILL.
REQ-005 In FILL, beat k (k = 1..BEATS-1) SHALL be stored at bits [k*BEAT_W +: BEAT_W] and increment beat_cnt.
REQ-006 Accepting beat BEATS-1 SHALL go to WRITE.
REQ-007 refill_ready SHALL be 1 in IDLE and FILL, and 0 in WRITE.
REQ-008 In WRITE, for exactly one cycle, outputs SHALL be: RW0_en=1, RW0_wmode=1, RW0_addr=latched idx, RW0_wmask=all ones, RW0_wdata=assembled row, refill_done=1. Next state SHALL be IDLE.
REQ-009 req_ready SHALL be 0 in WRITE.
REQ-010 req_ready SHALL be 0 in FILL when req_addr equals the latched idx (hazard block).
REQ-011 req_ready SHALL be 1 in all other cases.
REQ-012 An accepted core request SHALL drive the array combinationally in the same cycle: RW0_en=1, RW0_wmode=req_write, RW0_addr=req_addr.
REQ-013 An accepted core write SHALL additionally drive RW0_wmask=req_wmask and RW0_wdata=req_wdata.
REQ-014 An accepted core read SHALL drive RW0_wmask=0.
REQ-015 An accepted read SHALL give resp_valid=1 exactly one cycle later, with resp_data=RW0_rdata in that cycle (latency 1).
REQ-016 Writes SHALL produce no response.
REQ-017 A refill beat and a core request accepted in the same cycle SHALL both be honored; beats never touch the array before WRITE.
REQ-018 When no access is issued, RW0_en SHALL be 0 and RW0_wmode, RW0_wmask and RW0_wdata SHALL be 0.
REQ-019 beat_cnt SHALL be $clog2(BEATS) bits wide and wrap to 0 on entry to WRITE.

Reset
REQ-020 Asserting reset SHALL take effect immediately, independent of clock.
REQ-021 Reset SHALL force state=IDLE, beat_cnt=0, latched idx=0, row buffer=0, resp_valid=0, refill_done=0, and RW0_en=0.
REQ-022 Reset mid-FILL or mid-WRITE SHALL discard the partial row with no array write; the array contents are untouched.

Structure
REQ-023 A shared package SHALL hold the state enumeration and default ADDR_W, BEAT_W and BEATS.
REQ-024 One sub-module SHALL exist: refill_row_buffer (beat counter plus row assembly register).

Verification
REQ-025 Refill idx=0x1A3 with beats 0x11..11, 0x22..22, 0x33..33, 0x44..44 -> one write to 0x1A3 with row {44..,33..,22..,11..}, full mask, refill_done high 1 cycle after the 4th beat.
REQ-026 Core read of 0x005 during FILL of 0x1A3 -> accepted; resp_valid exactly 1 cycle later; resp_data = array content.
REQ-027 Core read of 0x1A3 during FILL of 0x1A3 -> req_ready=0 until after WRITE; the read then returns the new row.
REQ-028 Core write to 0x010 with wmask=0x0000000F -> only bytes 0..3 change; a subsequent read confirms it.
REQ-029 Core request arriving in WRITE -> req_ready=0; accepted the following cycle.
REQ-030 Reset asserted after 2 beats -> immediate IDLE and no RW0_en; a fresh 4-beat refill then completes correctly.
